// File: rtl/maze_pkg.sv
// rtl/maze_pkg.sv - shared types and constants for the maze game score path
package maze_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUN     = 2'd1,
      EXPIRED = 2'd2,
      OVER    = 2'd3
   } phase_t;

   typedef logic [3:0] bcd_digit_t;

   localparam logic [15:0] BCD_MAX = 16'h9999;

   // Two-digit packed BCD of a small binary constant (0..99).
   function automatic logic [7:0] bin2bcd8(input int unsigned v);
      return {4'(v / 10), 4'(v % 10)};
   endfunction

endpackage

// File: rtl/bcd_add4.sv
// rtl/bcd_add4.sv - saturating 4-digit packed-BCD adder (combinational)
module bcd_add4
   import maze_pkg::*;
(
   input  logic [15:0] a,
   input  logic [15:0] b,
   output logic [15:0] sum
);

   logic        carry;
   logic [4:0]  raw;
   bcd_digit_t  digit;
   logic [15:0] result;

   always_comb begin
      carry  = 1'b0;
      raw    = '0;
      digit  = '0;
      result = '0;
      for (int i = 0; i < 4; i++) begin
         raw = {1'b0, a[4*i +: 4]} + {1'b0, b[4*i +: 4]} + {4'b0000, carry};
         // Digits above 9 skip the six unused codes and carry into the next digit.
         if (raw > 5'd9) begin
            raw   = raw + 5'd6;
            carry = 1'b1;
         end else begin
            carry = 1'b0;
         end
         digit             = raw[3:0];
         result[4*i +: 4]  = digit;
      end
      sum = carry ? BCD_MAX : result;
   end

endmodule

// File: rtl/score_keeper.sv
// rtl/score_keeper.sv - score, level, countdown timer and high score for the maze game
// Optional time bonus on level completion is enabled by defining SCORE_TIME_BONUS_EN.
module score_keeper
   import maze_pkg::*;
#(
   parameter int          FRAMES_PER_SEC = 60,
   parameter int          LEVEL_TIME     = 99,
   parameter logic [15:0] COIN_POINTS    = 16'h0005,
   parameter int          MAX_LEVEL      = 9
) (
   input  logic        Clk,
   input  logic        Reset_n,
   input  logic        frame_clk,
   input  logic        inc,
   input  logic        score_CU,
   input  logic        clr,
   input  logic        H_STATE,
   input  logic        E_STATE,
   output logic [15:0] score,
   output logic [15:0] high_score,
   output logic [3:0]  level,
   output logic [7:0]  time_left,
   output logic        F_LAG
);

   localparam int         FW     = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;
   localparam logic [7:0] LT_BCD = bin2bcd8(LEVEL_TIME);

   phase_t         phase, phase_nxt;
   logic           fs1, fs2, fs3;
   logic           inc_q, coin_q;
   logic           frame_tick, inc_evt, coin_evt;
   logic [FW-1:0]  fcnt;
   logic [15:0]    coin_add, score_coin, score_nxt;
   logic [7:0]     time_dec;

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         fs1    <= 1'b0;
         fs2    <= 1'b0;
         fs3    <= 1'b0;
         inc_q  <= 1'b0;
         coin_q <= 1'b0;
      end else begin
         fs1    <= frame_clk;
         fs2    <= fs1;
         fs3    <= fs2;
         inc_q  <= inc;
         coin_q <= score_CU;
      end
   end

   assign frame_tick = fs2 & ~fs3;
   assign inc_evt    = inc & ~inc_q & (phase == RUN);
   assign coin_evt   = score_CU & ~coin_q & (phase == RUN);

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) phase <= IDLE;
      else          phase <= phase_nxt;
   end

   always_comb begin
      phase_nxt = phase;
      if (clr) begin
         phase_nxt = IDLE;
      end else begin
         case (phase)
            IDLE:    if (!H_STATE) phase_nxt = RUN;
            RUN:     if (E_STATE) phase_nxt = OVER;
                     else if (time_left == 8'h00) phase_nxt = EXPIRED;
            EXPIRED: if (E_STATE) phase_nxt = OVER;
            default: phase_nxt = phase;
         endcase
      end
   end

   assign coin_add = coin_evt ? COIN_POINTS : 16'h0000;

   bcd_add4 u_coin_add (.a(score), .b(coin_add), .sum(score_coin));

`ifdef SCORE_TIME_BONUS_EN
   logic [15:0] bonus_add;
   // The bonus uses the seconds left before the level reload takes effect.
   assign bonus_add = inc_evt ? {8'h00, time_left} : 16'h0000;
   bcd_add4 u_bonus_add (.a(score_coin), .b(bonus_add), .sum(score_nxt));
`else
   assign score_nxt = score_coin;
`endif

   assign time_dec = (time_left[3:0] == 4'd0) ? {time_left[7:4] - 4'd1, 4'd9}
                                              : {time_left[7:4], time_left[3:0] - 4'd1};

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         score      <= 16'h0000;
         high_score <= 16'h0000;
         level      <= 4'd0;
         time_left  <= LT_BCD;
         fcnt       <= '0;
         F_LAG      <= 1'b0;
      end else begin
         F_LAG <= (phase_nxt == EXPIRED);
         if (phase_nxt == OVER && phase != OVER && score_nxt > high_score)
            high_score <= score_nxt;
         if (phase_nxt == IDLE) begin
            score     <= 16'h0000;
            level     <= 4'd0;
            time_left <= LT_BCD;
            fcnt      <= '0;
         end else if (phase == RUN) begin
            score <= score_nxt;
            // A level reload wins over a timer step landing in the same cycle.
            if (inc_evt) begin
               if (level < 4'(MAX_LEVEL)) level <= level + 4'd1;
               time_left <= LT_BCD;
               fcnt      <= '0;
            end else if (frame_tick) begin
               if (fcnt == FW'(FRAMES_PER_SEC - 1)) begin
                  fcnt <= '0;
                  if (time_left != 8'h00) time_left <= time_dec;
               end else begin
                  fcnt <= fcnt + FW'(1);
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_score_keeper.sv
// tb/tb_score_keeper.sv - randomized self-checking bench for score_keeper against a decimal model
module tb_score_keeper;

   localparam int FPS = 3;
   localparam int LT  = 99;
   localparam int MAXL = 9;

   localparam int P_IDLE = 0, P_RUN = 1, P_EXP = 2, P_OVER = 3;

   logic        Clk = 1'b0;
   logic        Reset_n = 1'b0;
   logic        frame_clk = 1'b0, inc = 1'b0, score_CU = 1'b0, clr = 1'b0;
   logic        H_STATE = 1'b0, E_STATE = 1'b0;
   logic [15:0] score, high_score;
   logic [3:0]  level;
   logic [7:0]  time_left;
   logic        F_LAG;

   int n_checks = 0;
   int n_pass   = 0;

   int m_ph = P_IDLE;
   int m_score = 0, m_high = 0, m_level = 0, m_time = LT, m_frames = 0;

   score_keeper #(
      .FRAMES_PER_SEC(FPS), .LEVEL_TIME(LT), .COIN_POINTS(16'h0005), .MAX_LEVEL(MAXL)
   ) dut (
      .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk), .inc(inc), .score_CU(score_CU),
      .clr(clr), .H_STATE(H_STATE), .E_STATE(E_STATE), .score(score), .high_score(high_score),
      .level(level), .time_left(time_left), .F_LAG(F_LAG)
   );

   always #5 Clk = ~Clk;

   function automatic logic [15:0] to_bcd(input int v);
      return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   function automatic int min_i(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic check_all(input string tag);
      logic [15:0] t;
      t = to_bcd(m_time);
      check({tag, ".score"}, score, to_bcd(m_score));
      check({tag, ".high"},  high_score, to_bcd(m_high));
      check({tag, ".level"}, {12'h000, level}, 16'(m_level));
      check({tag, ".time"},  {8'h00, time_left}, {8'h00, t[7:0]});
      check({tag, ".flag"},  {15'h0, F_LAG}, {15'h0, (m_ph == P_EXP)});
   endtask

   task automatic model_coin();
      if (m_ph == P_RUN) m_score = min_i(m_score + 5, 9999);
   endtask

   task automatic model_inc();
      if (m_ph == P_RUN) begin
`ifdef SCORE_TIME_BONUS_EN
         m_score = min_i(m_score + m_time, 9999);
`endif
         m_level  = min_i(m_level + 1, MAXL);
         m_time   = LT;
         m_frames = 0;
      end
   endtask

   task automatic model_frame();
      if (m_ph == P_RUN) begin
         m_frames++;
         if (m_frames == FPS) begin
            m_frames = 0;
            if (m_time > 0) m_time--;
         end
         if (m_time == 0) m_ph = P_EXP;
      end
   endtask

   task automatic model_clear();
      m_ph = P_IDLE; m_score = 0; m_level = 0; m_time = LT; m_frames = 0;
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge Clk);
   endtask

   task automatic pulse(input bit c, input bit i, input int hold);
      @(negedge Clk);
      score_CU = c;
      inc      = i;
      tick(hold);
      score_CU = 1'b0;
      inc      = 1'b0;
      tick(2);
      if (c) model_coin();
      if (i) model_inc();
   endtask

   task automatic frame();
      @(negedge Clk);
      frame_clk = 1'b1;
      tick(3);
      frame_clk = 1'b0;
      tick(3);
      model_frame();
   endtask

   task automatic end_game(input string tag);
      E_STATE = 1'b1;
      tick(2);
      if (m_ph == P_RUN || m_ph == P_EXP) begin
         m_ph = P_OVER;
         if (m_score > m_high) m_high = m_score;
      end
      check_all(tag);
   endtask

   task automatic new_game(input bit hold_idle);
      @(negedge Clk);
      E_STATE = 1'b0;
      clr = 1'b1;
      tick(2);
      H_STATE = hold_idle;
      clr = 1'b0;
      model_clear();
      tick(2);
      if (hold_idle) begin
         pulse(1'b1, 1'b0, 3);
         check_all("idle_hold");
         H_STATE = 1'b0;
      end
      tick(2);
      m_ph = P_RUN;
   endtask

   initial begin
      tick(3);
      check_all("reset");

      Reset_n = 1'b1;
      clr = 1'b1;
      tick(5);
      clr = 1'b0;
      tick(2);
      m_ph = P_RUN;
      check_all("start");

      // Game 1: one long coin level counts once, then short coins to 300.
      pulse(1'b1, 1'b0, 1000);
      check_all("coin_long");
      for (int k = 0; k < 19; k++) begin
         pulse(1'b1, 1'b0, $urandom_range(1, 40));
         check_all("coin_rep");
      end
      check("score_100", score, 16'h0100);
      for (int k = 0; k < 40; k++) pulse(1'b1, 1'b0, $urandom_range(1, 4));
      end_game("over1");
      check("high_300", high_score, 16'h0300);

      // Game 2: held in IDLE by H_STATE first, lower final score.
      new_game(1'b1);
      check_all("game2_start");
      for (int k = 0; k < 40; k++) pulse(1'b1, 1'b0, $urandom_range(1, 4));
      check("score_200", score, 16'h0200);
      end_game("over2");
      check("high_kept", high_score, 16'h0300);

      // Game 3: coincident coin and level events with 45 seconds left.
      new_game(1'b0);
      for (int k = 0; k < 400 && m_time > 45; k++) frame();
      check("time_45", {8'h00, time_left}, 16'h0045);
      pulse(1'b1, 1'b1, 2);
      check_all("coin_inc");
      check("reload_99", {8'h00, time_left}, 16'h0099);

      for (int k = 0; k < 120; k++) begin
         case ($urandom_range(0, 3))
            0: pulse(1'b1, 1'b0, $urandom_range(1, 20));
            1: pulse(1'b0, 1'b1, $urandom_range(1, 5));
            2: frame();
            default: pulse(1'b1, 1'b1, $urandom_range(1, 5));
         endcase
         check_all("rand");
      end

      for (int k = 0; k < 2500 && m_score < 9999; k++) pulse(1'b1, 1'b0, 1);
      check_all("sat");
      pulse(1'b1, 1'b0, 1);
      check("score_sat", score, 16'h9999);

      for (int k = 0; k < 12; k++) pulse(1'b0, 1'b1, 1);
      check("level_sat", {12'h000, level}, 16'h0009);

      for (int k = 0; k < 400 && m_ph == P_RUN; k++) frame();
      check_all("expired");
      check("flag_set", {15'h0, F_LAG}, 16'h0001);
      pulse(1'b1, 1'b1, 2);
      frame();
      check_all("exp_hold");

      end_game("over3");
      check("flag_clr", {15'h0, F_LAG}, 16'h0000);

      @(negedge Clk);
      Reset_n = 1'b0;
      #1;
      check("reset_async_high", high_score, 16'h0000);
      m_high = 0;
      model_clear();
      E_STATE = 1'b0;
      tick(2);
      check_all("reset_mid");
      Reset_n = 1'b1;
      tick(2);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/score_keeper.md
SCORE_KEEPER -- requirements
Module: score_keeper

Interface
REQ-001 Parameters SHALL be: FRAMES_PER_SEC, default 60, frame ticks per timer second; LEVEL_TIME, default 99, seconds loaded at each level start (1..99); COIN_POINTS, default 16'h0005, BCD points per coin; MAX_LEVEL, default 9, highest level value.
REQ-002 Ports SHALL be: Clk  in  1  sole clock; Reset_n  in  1  asynchronous active-low reset.
REQ-003 frame_clk  in  1  vertical-sync level, asynchronous to Clk.
REQ-004 inc  in  1  level-complete request from game FSM; Clk-synchronous.
REQ-005 score_CU  in  1  coin-collected level; may stay high for many Clk cycles.
REQ-006 clr  in  1  new-game clear; level-sensitive.
REQ-007 H_STATE, E_STATE  in  1 each  game FSM idle/over flags.
REQ-008 score  out  16  4-digit packed BCD current score.
REQ-009 high_score  out  16  4-digit packed BCD best score.
REQ-010 level  out  4  binary level index.
REQ-011 time_left  out  8  2-digit packed BCD seconds remaining.
REQ-012 F_LAG  out  1  time-expired flag to game FSM.

Function
REQ-013 frame_clk SHALL pass a 2-flop synchronizer; each rising edge of the synchronized level SHALL produce a 1-cycle frame_tick.
REQ-014 inc and score_CU SHALL be rising-edge detected; each edge SHALL count as exactly one event.
REQ-015 Phase FSM states SHALL be IDLE, RUN, EXPIRED, OVER; reset state is IDLE.
REQ-016 IDLE->RUN when clr=0 and H_STATE=0; RUN->EXPIRED when time_left reaches 8'h00; RUN or EXPIRED->OVER when E_STATE=1; any state->IDLE when clr=1 (highest priority).
REQ-017 In IDLE: score=0, level=0, time_left=LEVEL_TIME (BCD), frame counter=0, and inc/coin events SHALL be ignored.
REQ-018 In RUN: a frame counter SHALL count frame_ticks 0..FRAMES_PER_SEC-1; on wrap, time_left SHALL decrement by one BCD step (e.g. 8'h10->8'h09).
REQ-019 In RUN: a coin event SHALL add COIN_POINTS to score in BCD, saturating at 16'h9999.
REQ-020 In RUN: an inc event SHALL increment level, saturating at MAX_LEVEL, SHALL reload time_left to LEVEL_TIME, and SHALL clear the frame counter.
REQ-021 Simultaneous coin and inc events in RUN SHALL both take effect in the same cycle; the inc reload SHALL override a same-cycle timer decrement.
REQ-022 F_LAG SHALL be registered, 1 exactly while in EXPIRED, and 0 otherwise.
REQ-023 On the OVER entry cycle, high_score SHALL load score if score > high_score (unsigned compare of the packed BCD value); clr SHALL NOT alter high_score.
REQ-024 In EXPIRED and OVER, score, level and time_left SHALL hold.
REQ-025 All outputs SHALL be registered; event-to-output latency SHALL be one Clk cycle after edge detection.

Reset
REQ-026 Reset_n=0 SHALL asynchronously force: phase IDLE, score=0, high_score=0, level=0, time_left=LEVEL_TIME, F_LAG=0, and synchronizer/edge flops=0.
REQ-027 Reset mid-game SHALL discard all progress, including high_score.

Configuration
REQ-028 With macro SCORE_TIME_BONUS_EN defined, an inc event in RUN SHALL also add the pre-reload time_left (as 16'h00XX BCD) to score, saturating, in addition to any same-cycle coin points.
REQ-029 Without SCORE_TIME_BONUS_EN, no time bonus SHALL be added and the bonus adder SHALL be absent.

Structure
REQ-030 Shared package maze_pkg SHALL hold the phase enum, the BCD max constant 16'h9999 and the BCD digit type.
REQ-031 One sub-module, bcd_add4, SHALL implement the saturating 4-digit packed-BCD adder; score_keeper SHALL instantiate it once, or twice when SCORE_TIME_BONUS_EN is defined.

Verification
REQ-032 Reset, then clr=1 for 5 cycles, then clr=0 and H_STATE=0 -> phase RUN, score=0, level=0, time_left=8'h99, F_LAG=0.
REQ-033 In RUN, score_CU held high for 1000 cycles -> score=16'h0005 (single event); repeat 20 times -> score=16'h0100.
REQ-034 In RUN with LEVEL_TIME=2 and FRAMES_PER_SEC=3, apply 6 frame_clk edges -> time_left 02->01->00, F_LAG=1; then E_STATE=1 -> F_LAG=0 and high_score=score.
REQ-035 score=16'h9997 plus one coin -> score=16'h9999; 12 inc pulses -> level=9.
REQ-036 Same cycle coin edge and inc edge with time_left=8'h45 -> score +5, level +1, time_left=8'h99 (+16'h0045 to score when SCORE_TIME_BONUS_EN is defined).
REQ-037 Game 1 ends with score 16'h0300, game 2 with 16'h0200, clr between games -> high_score=16'h0300 retained; Reset_n pulse -> high_score=0.
